dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the processor's single 8-bit data-memory port between the core load/store path and an external host requester (test loader or debug port). A three-state sequencer issues one registered memory command per grant, returns read data with a one-cycle acknowledge pulse, and raises a stall for the core while its access is pending. Sits between the core's `MemWrite`/`ALUOut`/`rd2_Data`/`ReadData` nets and a synchronous-read data RAM.

## Interface
- `AW`, 8: address width.
- `DW`, 8: data width.

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `core_req` in 1: core access request, held until `core_ack`.
- `core_we` in 1: 1 = write, 0 = read.
- `core_addr` in AW: core address.
- `core_wdata` in DW: core write data.
- `core_rdata` out DW: registered read data for the core.
- `core_ack` out 1: one-cycle completion pulse.
- `core_stall` out 1: `core_req & ~core_ack`, combinational.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_rdata`, `host_ack`: same semantics as the core equivalents.
- `host_lock` in 1: host atomic-sequence lock; used only under the configuration macro.
- `mem_en` out 1: registered memory command valid.
- `mem_we` out 1: registered write enable, qualified by `mem_en`.
- `mem_addr` out AW: registered address.
- `mem_wdata` out DW: registered write data.
- `mem_rdata` in DW: RAM read data, valid one cycle after `mem_en`.

## Operation
- States: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE: if neither request is high, stay. If exactly one is high, grant it. If both are high, grant the port not granted last. `last_grant` resets to HOST, so the core wins the first tie. On grant, register the winner's `we`, `addr` and `wdata` into the `mem_*` outputs, set `mem_en`, go to ISSUE.
- ISSUE: `mem_en` is high for exactly this cycle; the RAM performs the write or read at the end of it. Go to RESP.
- RESP: pulse the granted port's ack. On a read, `rdata` is loaded from `mem_rdata` at the start of RESP and is valid during the ack. On a write, `rdata` holds its previous value. Update `last_grant`, go to IDLE.
- Requests are not sampled in ISSUE or RESP. A requester keeping `req` high through its ack cycle is treated as a new request in the following IDLE.
- A requester must keep `req`/`we`/`addr`/`wdata` stable until ack. The arbiter captures them only in IDLE.
- Outputs not owned by a grant remain 0: `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are cleared whenever the next state is not ISSUE.

## Timing
- Reset values: state IDLE, `last_grant` HOST, all `mem_*` = 0, both `ack` = 0, both `rdata` = 0. `core_stall` equals `core_req` after reset.
- Latency: request seen in IDLE at cycle t, `mem_en` high in t+1, ack and `rdata` in t+2. Next grant is possible at t+3, for a throughput of one access per 3 cycles.
- With both ports continuously requesting, grants strictly alternate: C, H, C, H, ...
- `core_stall` is high from the core's request cycle up to, but not including, its ack cycle.
- Reset asserted while in ISSUE: the already-registered command still executes at that edge, because the RAM samples `mem_we` at the same edge. No ack is issued. The state returns to IDLE and the requester must re-request.
- Reset asserted in RESP: the ack for that cycle is still visible, and all state clears at the edge.
- Address wrap: none internal. `mem_addr` carries the full `AW` bits unmodified.

## Configuration
- `DMEM_ARB_HOST_LOCK_EN` defined: while `host_lock` = 1 in IDLE, the core is never granted. The host is granted when `host_req` = 1; otherwise the arbiter stays in IDLE. `last_grant` rotation is suspended while the lock is held. The lock is sampled only in IDLE, so a core access already in ISSUE/RESP completes.
- Not defined: `host_lock` is ignored and arbitration is pure alternating priority.

## Test plan
- Reset, then `core_req`=1, `core_we`=1, `addr`=0x10, `wdata`=0xA5 -> `mem_en`/`mem_we` high one cycle later with addr 0x10, data 0xA5; `core_ack` at t+2; `core_stall` high for cycles t and t+1.
- Host read of 0x10 after the above write -> `host_ack` at t+2 with `host_rdata`=0xA5; `core_rdata` unchanged.
- Both request from reset (core read 0x01, host read 0x02), held after each ack -> grant order C, H, C, H; acks every 3 cycles alternating ports.
- Core write 0x20=0x3C with `rst` asserted in its ISSUE cycle -> no `core_ack`; a later host read of 0x20 returns 0x3C; all outputs 0 in the cycle after reset.
- With `DMEM_ARB_HOST_LOCK_EN`: `host_lock`=1 with `core_req` held and host issuing two writes with an idle cycle between -> core never granted until `host_lock`=0, then granted in the next IDLE.
- Back-to-back core reads of 0xFF then 0x00 (req held continuously) -> two acks 3 cycles apart, each with correct `rdata`; `mem_addr` shows 0xFF then 0x00.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read data RAM port between core and host.
// Define DMEM_ARB_HOST_LOCK_EN to let host_lock hold off core grants.
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_ack,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack,
    input  logic          host_lock,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t        state;
    logic          last_host;
    logic          gnt_host;
    logic          op_we;
    logic          hold_rot;
    logic [DW-1:0] core_rdata_q;
    logic [DW-1:0] host_rdata_q;

    logic lock;
`ifdef DMEM_ARB_HOST_LOCK_EN
    assign lock = host_lock;
`else
    logic unused_lock;
    assign unused_lock = host_lock;
    assign lock = 1'b0;
`endif

    logic pick_core;
    logic pick_host;

    // Tie goes to whichever port did not win the previous grant.
    always_comb begin
        pick_core = 1'b0;
        pick_host = 1'b0;
        if (lock) begin
            pick_host = host_req;
        end else if (core_req && host_req) begin
            pick_core = last_host;
            pick_host = ~last_host;
        end else begin
            pick_core = core_req;
            pick_host = host_req;
        end
    end

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign sel_we    = pick_host ? host_we    : core_we;
    assign sel_addr  = pick_host ? host_addr  : core_addr;
    assign sel_wdata = pick_host ? host_wdata : core_wdata;

    // RAM data arrives during the ack cycle, so reads bypass the holding register.
    assign core_rdata = (core_ack && !op_we) ? mem_rdata : core_rdata_q;
    assign host_rdata = (host_ack && !op_we) ? mem_rdata : host_rdata_q;
    assign core_stall = core_req & ~core_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_host    <= 1'b1;
            gnt_host     <= 1'b0;
            op_we        <= 1'b0;
            hold_rot     <= 1'b0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
            core_ack     <= 1'b0;
            host_ack     <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            core_ack  <= 1'b0;
            host_ack  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_core || pick_host) begin
                        state     <= ISSUE;
                        gnt_host  <= pick_host;
                        hold_rot  <= lock;
                        op_we     <= sel_we;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                    end
                end
                ISSUE: begin
                    state    <= RESP;
                    core_ack <= ~gnt_host;
                    host_ack <= gnt_host;
                end
                RESP: begin
                    state        <= IDLE;
                    core_rdata_q <= core_rdata;
                    host_rdata_q <= host_rdata;
                    if (!hold_rot) begin
                        last_host <= gnt_host;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
